// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame checker, set-2 decoder, event FIFO.
// Ports: Clk, Reset_n; raw PS2_Clk/PS2_Data; Event_* FWFT valid/ready; Frame_Err, Overflow pulses; Fifo_Count.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  parameter bit REPEAT_FILTER  = 1'b1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        PS2_Clk,
  input  logic                        PS2_Data,
  output logic                        Event_Valid,
  input  logic                        Event_Ready,
  output logic [7:0]                  Event_Code,
  output logic                        Event_Press,
  output logic                        Event_Ext,
  output logic                        Frame_Err,
  output logic                        Overflow,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] FLT_LAST =
    8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT =
    CW'(FIFO_DEPTH);

  typedef struct packed {
    logic       ext;
    logic       press;
    logic [7:0] code;
  } event_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], PS2_Clk};
      dat_sync <= {dat_sync[0], PS2_Data};
    end
  end

  // A line only changes after FILTER_LEN
  // consecutive samples disagree with it.
  logic       clk_f;
  logic       dat_f;
  logic [7:0] clk_cnt;
  logic [7:0] dat_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_f   <= 1'b1;
      clk_cnt <= '0;
    end else if (clk_sync[1] == clk_f) begin
      clk_cnt <= '0;
    end else if (clk_cnt == FLT_LAST) begin
      clk_f   <= clk_sync[1];
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dat_f   <= 1'b1;
      dat_cnt <= '0;
    end else if (dat_sync[1] == dat_f) begin
      dat_cnt <= '0;
    end else if (dat_cnt == FLT_LAST) begin
      dat_f   <= dat_sync[1];
      dat_cnt <= '0;
    end else begin
      dat_cnt <= dat_cnt + 8'd1;
    end
  end

  logic clk_prev;
  logic fall;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) clk_prev <= 1'b1;
    else          clk_prev <= clk_f;
  end

  assign fall = clk_prev & ~clk_f;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          frame_err;

  logic in_frame;
  logic tmo;
  logic stop_edge;
  logic byte_ok;
  logic bad;

  // Good byte: stop bit 1 and odd parity
  // over the eight data bits plus parity.
  always_comb begin
    in_frame  = (state != S_IDLE);
    tmo       = in_frame & ~fall &
                (tcnt == TMO_LAST);
    stop_edge = (state == S_STOP) & fall;
    byte_ok   = stop_edge & dat_f &
                (^{shift, par});
    bad       = tmo |
                (stop_edge & ~byte_ok) |
                ((state == S_IDLE) & fall & dat_f);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad;
      if (!in_frame || fall) tcnt <= '0;
      else                   tcnt <= tcnt + TW'(1);
      if (tmo) begin
        state <= S_IDLE;
      end else if (fall) begin
        unique case (state)
          S_IDLE: begin
            if (!dat_f) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shift   <= {dat_f, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par   <= dat_f;
            state <= S_STOP;
          end
          S_STOP:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign Frame_Err = frame_err;

  logic       ext_q;
  logic       brk_q;
  logic       lm_valid;
  logic [8:0] lm_key;
  logic       ev_push;
  event_t     ev_q;
  logic [8:0] key;
  logic       lm_hit;

  assign key    = {ext_q, shift};
  assign lm_hit = lm_valid & (lm_key == key);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      lm_valid <= 1'b0;
      lm_key   <= '0;
      ev_push  <= 1'b0;
      ev_q     <= '0;
    end else begin
      ev_push <= 1'b0;
      if (bad) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_ok) begin
        unique case (1'b1)
          (shift == 8'hE0): ext_q <= 1'b1;
          (shift == 8'hF0): brk_q <= 1'b1;
          (shift == 8'hE1): begin
          end
          default: begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            ev_q  <= {ext_q, ~brk_q, shift};
            if (brk_q) begin
              ev_push <= 1'b1;
              if (lm_hit) lm_valid <= 1'b0;
            end else if (!(REPEAT_FILTER && lm_hit)) begin
              ev_push  <= 1'b1;
              lm_valid <= 1'b1;
              lm_key   <= key;
            end
          end
        endcase
      end
    end
  end

  event_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          pop;
  logic          full;
  logic          push;
  event_t        head;

  assign Event_Valid = (count != '0);
  assign pop         = Event_Valid & Event_Ready;
  assign full        = (count == FULL_CNT);
  // A pop frees the slot the push needs,
  // so both proceed when full.
  assign push        = ev_push & (~full | pop);

  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= ev_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= ev_push & full & ~pop;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head        = mem[rptr];
  assign Event_Code  = Event_Valid ? head.code : '0;
  assign Event_Press = Event_Valid & head.press;
  assign Event_Ext   = Event_Valid & head.ext;
  assign Overflow    = ovf;
  assign Fifo_Count  = count;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx.
// Drives PS/2 frames, checks events against tables and a reference model.
module tb_ps2_keyboard_rx;

  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int FD = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       PS2_Clk = 1'b1;
  logic       PS2_Data = 1'b1;
  logic       Event_Ready = 1'b0;
  logic       Event_Valid;
  logic [7:0] Event_Code;
  logic       Event_Press;
  logic       Event_Ext;
  logic       Frame_Err;
  logic       Overflow;
  logic [2:0] Fifo_Count;

  ps2_keyboard_rx #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH(FD),
    .REPEAT_FILTER(1'b1)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .PS2_Clk(PS2_Clk),
    .PS2_Data(PS2_Data),
    .Event_Valid(Event_Valid),
    .Event_Ready(Event_Ready),
    .Event_Code(Event_Code),
    .Event_Press(Event_Press),
    .Event_Ext(Event_Ext),
    .Frame_Err(Frame_Err),
    .Overflow(Overflow),
    .Fifo_Count(Fifo_Count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int n_err = 0;
  int n_ovf = 0;
  int n_vcyc = 0;
  logic [9:0] got_q[$];

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (Event_Valid && Event_Ready)
        got_q.push_back({Event_Ext, Event_Press, Event_Code});
      if (Frame_Err) n_err <= n_err + 1;
      if (Overflow) n_ovf <= n_ovf + 1;
      if (Event_Valid) n_vcyc <= n_vcyc + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  int stop_cyc = 0;
  int last_fall = 0;
  bit stop_flag = 1'b0;

  // gl: bit index whose clock-high phase gets a 3-cycle low glitch
  task automatic ps2_bits(input logic [10:0] fr, input int nb, input int gl);
    stop_flag = 1'b0;
    for (int i = 0; i < nb; i++) begin
      PS2_Data = fr[i];
      tick(10);
      PS2_Clk = 1'b0;
      last_fall = cyc;
      if (i == 10) begin
        stop_cyc = cyc;
        stop_flag = 1'b1;
      end
      tick(20);
      PS2_Clk = 1'b1;
      if (i == gl) begin
        tick(4);
        PS2_Clk = 1'b0;
        tick(3);
        PS2_Clk = 1'b1;
        tick(3);
      end else begin
        tick(10);
      end
    end
    PS2_Data = 1'b1;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bp);
    return {1'b1, (~^b) ^ bp, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, input logic bp);
    ps2_bits(mkframe(b, bp), 11, -1);
  endtask

  bit m_ext = 1'b0;
  bit m_brk = 1'b0;
  int m_last = -1;
  int m_errs = 0;
  logic [9:0] exp_q[$];

  function automatic void model_byte(input logic [7:0] b, input logic bp);
    int k;
    if (bp) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_errs++;
      return;
    end
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b != 8'hE1) begin
      k = (m_ext ? 256 : 0) + int'(b);
      if (m_brk) begin
        exp_q.push_back({m_ext, 1'b0, b});
        if (k == m_last) m_last = -1;
      end else if (k != m_last) begin
        exp_q.push_back({m_ext, 1'b1, b});
        m_last = k;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  typedef struct packed {
    logic [7:0] b;
    logic       bp;
    logic       ev;
    logic [9:0] exp;
    logic       err;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];
  logic [7:0] pool [6];

  int e0, r0, v0, o0, lat, dly, nm;
  bit done;
  logic [7:0] rb;
  logic rbp;
  logic [2:0] base;

  initial begin
    tv[0]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 1'b1};
    tv[1]  = '{8'h1C, 1'b0, 1'b1, 10'h11C, 1'b0};
    tv[2]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[3]  = '{8'h75, 1'b0, 1'b1, 10'h375, 1'b0};
    tv[4]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[5]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[6]  = '{8'h75, 1'b0, 1'b1, 10'h275, 1'b0};
    tv[7]  = '{8'h1C, 1'b0, 1'b1, 10'h11C, 1'b0};
    tv[8]  = '{8'h1C, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[9]  = '{8'h1C, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[10] = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[11] = '{8'h1C, 1'b0, 1'b1, 10'h01C, 1'b0};
    tv[12] = '{8'h1C, 1'b0, 1'b1, 10'h11C, 1'b0};
    tv[13] = '{8'hE1, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[14] = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[15] = '{8'h33, 1'b1, 1'b0, 10'h000, 1'b1};
    tv[16] = '{8'h33, 1'b0, 1'b1, 10'h133, 1'b0};
    tv[17] = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[18] = '{8'hE1, 1'b0, 1'b0, 10'h000, 1'b0};
    tv[19] = '{8'h6B, 1'b0, 1'b1, 10'h36B, 1'b0};
    pool = '{8'h1C, 8'h1D, 8'h75, 8'h6B, 8'h29, 8'h5A};

    tick(4);
    chk("rst_outs", {Event_Valid, Event_Code, Event_Press, Event_Ext,
                     Frame_Err, Overflow, Fifo_Count}, 0);
    Reset_n = 1'b1;
    tick(3);
    chk("post_rst_outs", {Event_Valid, Event_Code, Event_Press, Event_Ext,
                          Frame_Err, Overflow, Fifo_Count}, 0);

    Event_Ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      e0 = got_q.size();
      r0 = n_err;
      v0 = n_vcyc;
      send(tv[i].b, tv[i].bp);
      tick(10);
      chk($sformatf("tv%0d_nev", i), got_q.size() - e0, int'(tv[i].ev));
      if (tv[i].ev)
        chk($sformatf("tv%0d_event", i), int'(got_q[got_q.size() - 1]), int'(tv[i].exp));
      chk($sformatf("tv%0d_err", i), n_err - r0, int'(tv[i].err));
      chk($sformatf("tv%0d_vcyc", i), n_vcyc - v0, int'(tv[i].ev));
    end

    // timeout: start bit plus four data bits, then silence
    r0 = n_err;
    ps2_bits(mkframe(8'h29, 1'b0), 5, -1);
    for (int k = 0; k < 1200 && n_err == r0; k++) tick(1);
    dly = cyc - last_fall;
    chk("tmo_err", n_err - r0, 1);
    total++;
    if (dly < TO || dly > TO + 40) begin
      bad++;
      $display("FAIL tmo_delay: got %0d want %0d..%0d", dly, TO, TO + 40);
    end
    e0 = got_q.size();
    r0 = n_err;
    send(8'h29, 1'b0);
    tick(10);
    chk("tmo_next_nev", got_q.size() - e0, 1);
    if (got_q.size() > e0)
      chk("tmo_next_event", int'(got_q[got_q.size() - 1]), 'h129);
    chk("tmo_next_err", n_err - r0, 0);

    // overflow with consumer stalled
    Event_Ready = 1'b0;
    e0 = got_q.size();
    lat = 0;
    fork
      send(8'h15, 1'b0);
      begin
        wait (stop_flag);
        base = Fifo_Count;
        for (int k = 0; k < 100; k++) begin
          tick(1);
          if (Fifo_Count != base) begin
            lat = cyc - stop_cyc;
            break;
          end
        end
      end
    join
    chk("latency", lat, 2 + FL + 2);
    if (lat < 2) lat = 2 + FL + 2;
    send(8'h1D, 1'b0);
    send(8'h24, 1'b0);
    send(8'h2D, 1'b0);
    tick(5);
    chk("fill_count", Fifo_Count, 4);
    o0 = n_ovf;
    send(8'h2C, 1'b0);
    tick(5);
    chk("ovf_pulse", n_ovf - o0, 1);
    chk("ovf_count", Fifo_Count, 4);
    o0 = n_ovf;
    fork
      send(8'h35, 1'b0);
      begin
        wait (stop_flag);
        tick(lat - 1);
        Event_Ready = 1'b1;
        tick(1);
        Event_Ready = 1'b0;
      end
    join
    tick(5);
    chk("coinc_count", Fifo_Count, 4);
    chk("coinc_ovf", n_ovf - o0, 0);
    chk("coinc_pop_n", got_q.size() - e0, 1);
    if (got_q.size() > e0)
      chk("coinc_pop", int'(got_q[e0]), 'h115);
    e0 = got_q.size();
    Event_Ready = 1'b1;
    tick(10);
    chk("drain_n", got_q.size() - e0, 4);
    if (got_q.size() - e0 == 4) begin
      chk("drain0", int'(got_q[e0]), 'h11D);
      chk("drain1", int'(got_q[e0 + 1]), 'h124);
      chk("drain2", int'(got_q[e0 + 2]), 'h12D);
      chk("drain3", int'(got_q[e0 + 3]), 'h135);
    end
    chk("drain_count", Fifo_Count, 0);

    // glitches: idle, then mid-frame
    e0 = got_q.size();
    r0 = n_err;
    tick(5);
    PS2_Clk = 1'b0;
    tick(3);
    PS2_Clk = 1'b1;
    tick(30);
    chk("glitch_idle_err", n_err - r0, 0);
    chk("glitch_idle_nev", got_q.size() - e0, 0);
    ps2_bits(mkframe(8'h4D, 1'b0), 11, 3);
    tick(10);
    chk("glitch_frame_nev", got_q.size() - e0, 1);
    if (got_q.size() > e0)
      chk("glitch_frame_event", int'(got_q[got_q.size() - 1]), 'h14D);
    chk("glitch_frame_err", n_err - r0, 0);

    // reset with queued events and a partial frame
    Event_Ready = 1'b0;
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    tick(5);
    chk("rq_count", Fifo_Count, 2);
    ps2_bits(mkframe(8'h23, 1'b0), 5, -1);
    Reset_n = 1'b0;
    tick(3);
    chk("rq_in_rst", {Event_Valid, Fifo_Count}, 0);
    Reset_n = 1'b1;
    tick(2);
    chk("rq_after", {Event_Valid, Fifo_Count}, 0);
    Event_Ready = 1'b1;
    e0 = got_q.size();
    r0 = n_err;
    send(8'h2B, 1'b0);
    tick(10);
    chk("rq_next_nev", got_q.size() - e0, 1);
    if (got_q.size() > e0)
      chk("rq_next_event", int'(got_q[got_q.size() - 1]), 'h12B);
    chk("rq_next_err", n_err - r0, 0);

    // random byte stream against the model
    Reset_n = 1'b0;
    tick(3);
    Reset_n = 1'b1;
    tick(2);
    got_q.delete();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_last = -1;
    m_errs = 0;
    r0 = n_err;
    o0 = n_ovf;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 9))
            0: rb = 8'hE0;
            1: rb = 8'hF0;
            2: rb = 8'hE1;
            default: rb = pool[$urandom_range(0, 5)];
          endcase
          rbp = ($urandom_range(0, 9) == 0);
          model_byte(rb, rbp);
          send(rb, rbp);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick(1);
          Event_Ready = 1'($urandom_range(0, 1));
        end
      end
    join
    Event_Ready = 1'b1;
    tick(20);
    chk("rnd_nev", got_q.size(), exp_q.size());
    nm = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nm; i++)
      chk($sformatf("rnd_ev%0d", i), int'(got_q[i]), int'(exp_q[i]));
    chk("rnd_errs", n_err - r0, m_errs);
    chk("rnd_ovf", n_ovf - o0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
